// File: rtl/fifo_sched_pkg.sv
// Shared types for the per-port RX FIFO round-robin scheduler.
package fifo_sched_pkg;
  localparam int NQ_DEF     = 4;
  localparam int DWIDTH_DEF = 9;
  localparam int LAST_BIT   = DWIDTH_DEF - 1;

  typedef logic [$clog2(NQ_DEF)-1:0] qid_t;
  typedef logic [DWIDTH_DEF-1:0]     word_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } sched_state_t;
endpackage

// File: rtl/fifo_rr_sched_if.sv
// Queue-side and stream-side signals of the scheduler; master is the scheduler.
interface fifo_rr_sched_if #(
  parameter int NQ     = 4,
  parameter int DWIDTH = 9
);
  localparam int QW = $clog2(NQ);

  logic [NQ-1:0]             q_empty;
  logic [NQ-1:0][DWIDTH-1:0] q_dout_comb;
  logic [NQ-1:0]             q_re;
  logic [NQ-1:0]             q_en;
  logic [DWIDTH-2:0]         out_data;
  logic                      out_last;
  logic [QW-1:0]             out_qid;
  logic                      out_valid;
  logic                      out_ready;
  logic                      trunc_err;
  logic                      stall_err;
  logic                      busy;

  modport master (
    input  q_empty, q_dout_comb, q_en, out_ready,
    output q_re, out_data, out_last, out_qid, out_valid, trunc_err, stall_err, busy
  );

  modport slave (
    output q_empty, q_dout_comb, q_en, out_ready,
    input  q_re, out_data, out_last, out_qid, out_valid, trunc_err, stall_err, busy
  );
endinterface

// File: rtl/fifo_rr_sched_arb.sv
// Combinational rotating-priority picker: first requester strictly after last_gnt.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);
  // Walk from farthest to nearest so the nearest requester wins the last write.
  always_comb begin
    gnt_idx = last_gnt;
    gnt_vld = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[IW'((int'(last_gnt) + k) % N)]) begin
        gnt_idx = IW'((int'(last_gnt) + k) % N);
        gnt_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fifo_rr_sched.sv
// Packet-granular round-robin drain of NQ look-ahead FIFOs into one valid/ready stream,
// with forced truncation at MAXLEN words and abort on a stalled queue.
module fifo_rr_sched
  import fifo_sched_pkg::*;
#(
  parameter int NQ        = 4,
  parameter int DWIDTH    = 9,
  parameter int MAXLEN    = 1536,
  parameter int STALL_MAX = 255
) (
  input  logic            clk,
  input  logic            arst,
  fifo_rr_sched_if.master bus
);
  localparam int QW = $clog2(NQ);
  localparam int WW = $clog2(MAXLEN + 1);
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [WW-1:0] WCNT_TRUNC = WW'(MAXLEN - 1);
  localparam logic [SW-1:0] SCNT_MAX   = SW'(STALL_MAX);

  sched_state_t  state_q, state_d;
  logic [QW-1:0] sel_q, sel_d;
  logic [QW-1:0] last_gnt_q, last_gnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;

  logic [NQ-1:0]     elig;
  logic [QW-1:0]     gnt_idx;
  logic              gnt_vld;
  logic [DWIDTH-1:0] cur_word;
  logic              cur_empty, in_xfer, valid, xfer, forced, last, stall;

  assign elig = bus.q_en & ~bus.q_empty;

  rr_arbiter #(.N(NQ)) u_arb (
    .req      (elig),
    .last_gnt (last_gnt_q),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld)
  );

  // Everything feeding q_re comes from registered state, FIFO empty and out_ready only.
  assign cur_word  = bus.q_dout_comb[sel_q];
  assign cur_empty = bus.q_empty[sel_q];
  assign in_xfer   = (state_q == XFER);
  assign valid     = in_xfer & ~cur_empty;
  assign xfer      = valid & bus.out_ready;
  assign forced    = (wcnt_q == WCNT_TRUNC);
  assign last      = cur_word[DWIDTH-1] | forced;
  assign stall     = in_xfer & cur_empty & (scnt_q == SCNT_MAX);

  assign bus.q_re      = xfer ? ({{(NQ-1){1'b0}}, 1'b1} << sel_q) : '0;
  assign bus.out_data  = cur_word[DWIDTH-2:0];
  assign bus.out_last  = last;
  assign bus.out_qid   = sel_q;
  assign bus.out_valid = valid;
  assign bus.trunc_err = xfer & forced & ~cur_word[DWIDTH-1];
  assign bus.stall_err = stall;
  assign bus.busy      = in_xfer;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_gnt_d = last_gnt_q;
    wcnt_d     = wcnt_q;
    scnt_d     = scnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          sel_d      = gnt_idx;
          last_gnt_d = gnt_idx;
          wcnt_d     = '0;
          scnt_d     = '0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (xfer) begin
          wcnt_d = wcnt_q + 1'b1;
          scnt_d = '0;
          if (last) state_d = IDLE;
        end else if (stall) begin
          state_d = IDLE;
        end else if (cur_empty) begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      last_gnt_q <= QW'(NQ - 1);
      wcnt_q     <= '0;
      scnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_gnt_q <= last_gnt_d;
      wcnt_q     <= wcnt_d;
      scnt_q     <= scnt_d;
    end
  end

  a_q_re_onehot: assert property (@(posedge clk) disable iff (arst) $onehot0(bus.q_re));
endmodule
